position_display: RTL
=====================

// Module: position_display
// PURPOSE
// - Consumer end of the game core's status outputs: pos1/pos2 (0-99), winner code, turn.
// - Drives a 4-digit multiplexed common-anode 7-segment display: P1 tens/ones on digits 3/2, P2 tens/ones on digits 1/0.
// - Blinks the winner's digits and lights a decimal point on the side whose turn it is.
// - Sits between snakes_ladders status outputs and board pins; no feedback into game logic.
// PARAMETERS
// - DIGIT_TICKS  50000  clk cycles each digit is driven (scan period per digit); must be >= 2
// - BLINK_FRAMES 64     full 4-digit frames per blink half-period; must be >= 1
// PORTS
// - clk     input  1  single system clock; all state on rising edge
// - reset   input  1  asynchronous, active-low reset (asserted when 0)
// - pos1    input  7  player 1 position, binary
// - pos2    input  7  player 2 position, binary
// - winner  input  2  0 = P1 won, 1 = P2 won, 2 = no winner, 3 = treated as 2
// - turn    input  1  0 = P1 to move, 1 = P2 to move
// - seg_n   output 7  segments {g,f,e,d,c,b,a}, active-low
// - an_n    output 4  digit enables, active-low; an_n[i] selects digit i
// - dp_n    output 1  decimal point, active-low
// BEHAVIOUR
// - Reset: seg_n=7'h7F, an_n=4'hF, dp_n=1; tick_cnt=0, digit_idx=3, frame_cnt=0, blink_phase=0 (visible);
//   snapshot regs pos1_s=0, pos2_s=0, win_s=2, turn_s=0.
// - tick_cnt counts 0..DIGIT_TICKS-1 and wraps; "tick" = cycle where tick_cnt==DIGIT_TICKS-1.
// - On each tick: digit_idx decrements 3->2->1->0->3 (wraps); outputs registered on same edge, so
//   new digit is visible 1 cycle after tick. Outputs stay all-off from reset until the first tick.
// - Frame snapshot: on the tick where digit_idx moves 0->3, and on the very first tick after reset,
//   pos1/pos2/winner/turn captured into snapshot regs; display uses only snapshot regs, so input
//   changes mid-frame never appear until the next frame (no tearing). Inputs are sync to clk.
// - Snapshot capture and digit drive occur on the same edge: digit 3 of a new frame shows the new snapshot.
// - Digit value: value<=99 -> tens=value/10, ones=value%10, leading zero shown (7 -> "07").
//   value>=100 -> both digits of that player show dash (only g lit: seg_n=7'b0111111).
// - Segment codes (seg_n): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000.
// - Blink: frame_cnt counts frames 0..BLINK_FRAMES-1; on wrap blink_phase toggles.
//   If win_s==0 and blink_phase==1, digits 3/2 are blanked (an_n bit held 1, seg_n=7'h7F);
//   likewise digits 1/2... i.e. win_s==1 blanks digits 1/0. win_s 2 or 3: no blanking.
// - Winner change resets nothing: blink_phase keeps running; blink takes effect next frame.
// - dp_n=0 only while driving digit 2 with turn_s==0, or digit 0 with turn_s==1, and that digit
//   not blanked; dp suppressed (1) whenever win_s is 0 or 1 (game over).
// - Exactly one an_n bit low at any time after first tick (or none when blanked).
// - Reset assertion mid-scan: all outputs to reset values immediately (asynchronous), no glitch to other digits.
// STRUCTURE
// - Shared package snl_pkg: SEG_DIGIT[0:9] and SEG_DASH/SEG_OFF constants, WIN_P1/WIN_P2/WIN_NONE
//   codes, BOARD_MAX=99, POS_W=7.
// - One sub-module seg7_digit_enc: 7-bit position + select(tens/ones) -> seg_n pattern, incl. dash rule;
//   combinational, instantiated once on the muxed snapshot value.
// - Top holds tick/digit/frame counters, blink phase, snapshot regs, output registers.
// TESTING (DIGIT_TICKS=4, BLINK_FRAMES=2 in bench)
// - Hold reset=0, toggle clk -> seg_n=7F, an_n=F, dp_n=1; release -> still all-off for first 3 cycles, digit 3 on at cycle 4+1.
// - pos1=42, pos2=7, winner=2, turn=0 -> frame shows an_n 0111/1011/1101/1110 with seg_n 0011001/0100100/1000000/1111000; dp_n=0 only on digit 2.
// - pos1=100, pos2=99 -> digits 3,2 seg_n=0111111; digits 1,0 seg_n=0010000.
// - winner=1 -> after BLINK_FRAMES frames digits 1/0 blanked (an_n=F, seg_n=7F) for 2 frames, then visible 2 frames; dp_n stays 1.
// - Change pos1 from 42 to 55 while digit 2 active -> digit 2 still shows 2 this frame; next frame shows 5,5.
// - Assert reset while digit 1 driven -> outputs off same cycle (async); after release scan restarts at digit 3 with snapshot of current inputs.

Source files
------------

// File: rtl/snl_pkg.sv
// Shared constants for the snakes-and-ladders status display: segment font, winner codes,
// board limits and the frame snapshot record.
package snl_pkg;

  localparam int POS_W     = 7;
  localparam int BOARD_MAX = 99;

  localparam logic [1:0] WIN_P1   = 2'd0;
  localparam logic [1:0] WIN_P2   = 2'd1;
  localparam logic [1:0] WIN_NONE = 2'd2;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic {
    SEL_ONES = 1'b0,
    SEL_TENS = 1'b1
  } digit_sel_e;

  typedef struct packed {
    logic [POS_W-1:0] pos1;
    logic [POS_W-1:0] pos2;
    logic [1:0]       win;
    logic             turn;
  } snap_t;

  function automatic logic is_game_over(input logic [1:0] win);
    return (win == WIN_P1) || (win == WIN_P2);
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// Combinational encoder: board position plus tens/ones select to an active-low 7-segment
// pattern. Positions beyond the board show a dash on both digits.
module seg7_digit_enc
  import snl_pkg::*;
(
  input  logic [POS_W-1:0] i_value,
  input  digit_sel_e       i_sel,
  output logic [6:0]       o_seg_n
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [3:0] w_digit;
  logic       w_off_board;

  assign w_tens      = 4'(i_value / POS_W'(10));
  assign w_ones      = 4'(i_value % POS_W'(10));
  assign w_digit     = (i_sel == SEL_TENS) ? w_tens : w_ones;
  assign w_off_board = i_value > POS_W'(BOARD_MAX);

  always_comb begin
    o_seg_n = SEG_OFF;
    if (w_off_board) begin
      o_seg_n = SEG_DASH;
    end else if (w_digit <= 4'd9) begin
      o_seg_n = SEG_DIGIT[w_digit];
    end
  end

endmodule

// File: rtl/position_display.sv
// 4-digit multiplexed display of both player positions, with winner blink and turn
// indicator. Inputs are captured once per frame so a frame never mixes old and new values.
module position_display
  import snl_pkg::*;
#(
  parameter int DIGIT_TICKS  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [POS_W-1:0] pos1,
  input  logic [POS_W-1:0] pos2,
  input  logic [1:0]       winner,
  input  logic             turn,
  output logic [6:0]       seg_n,
  output logic [3:0]       an_n,
  output logic             dp_n
);

  localparam int TW = $clog2(DIGIT_TICKS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [TW-1:0] r_tick_cnt;
  logic [1:0]    r_digit_idx;
  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_phase;
  logic          r_started;
  snap_t         r_snap;
  logic [6:0]    r_seg_n;
  logic [3:0]    r_an_n;
  logic          r_dp_n;

  logic          w_tick;
  logic          w_new_frame;
  logic          w_frame_wrap;
  logic          w_phase;
  logic [1:0]    w_next_idx;
  snap_t         w_in;
  snap_t         w_src;
  logic          w_p1_side;
  logic          w_blank;
  logic          w_dp_on;
  logic [POS_W-1:0] w_value;
  digit_sel_e    w_sel;
  logic [6:0]    w_seg_n;

  assign w_tick      = (r_tick_cnt == TICK_LAST);
  // The first tick after reset opens a frame on digit 3 without stepping the index
  assign w_new_frame = !r_started || (r_digit_idx == 2'd0);
  assign w_next_idx  = r_started ? (r_digit_idx - 2'd1) : 2'd3;

  assign w_in  = '{pos1: pos1, pos2: pos2, win: winner, turn: turn};
  assign w_src = w_new_frame ? w_in : r_snap;

  assign w_frame_wrap = r_started && w_new_frame && (r_frame_cnt == FRAME_LAST);
  assign w_phase      = w_frame_wrap ? ~r_blink_phase : r_blink_phase;

  assign w_p1_side = w_next_idx[1];
  assign w_value   = w_p1_side ? w_src.pos1 : w_src.pos2;
  assign w_sel     = w_next_idx[0] ? SEL_TENS : SEL_ONES;
  assign w_blank   = w_phase && (((w_src.win == WIN_P1) && w_p1_side) ||
                                 ((w_src.win == WIN_P2) && !w_p1_side));
  assign w_dp_on   = !w_blank && !is_game_over(w_src.win) &&
                     (((w_next_idx == 2'd2) && !w_src.turn) ||
                      ((w_next_idx == 2'd0) &&  w_src.turn));

  seg7_digit_enc u_enc (
    .i_value (w_value),
    .i_sel   (w_sel),
    .o_seg_n (w_seg_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt    <= '0;
      r_digit_idx   <= 2'd3;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_started     <= 1'b0;
      r_snap        <= '{pos1: '0, pos2: '0, win: WIN_NONE, turn: 1'b0};
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      if (w_tick) begin
        r_started     <= 1'b1;
        r_digit_idx   <= w_next_idx;
        r_blink_phase <= w_phase;
        if (w_new_frame) begin
          r_snap <= w_in;
        end
        if (r_started && w_new_frame) begin
          r_frame_cnt <= w_frame_wrap ? '0 : r_frame_cnt + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg_n <= SEG_OFF;
      r_an_n  <= 4'hF;
      r_dp_n  <= 1'b1;
    end else if (w_tick) begin
      r_seg_n <= w_blank ? SEG_OFF : w_seg_n;
      r_an_n  <= w_blank ? 4'hF : ~(4'b0001 << w_next_idx);
      r_dp_n  <= ~w_dp_on;
    end
  end

  assign seg_n = r_seg_n;
  assign an_n  = r_an_n;
  assign dp_n  = r_dp_n;

endmodule
